// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light command path.
//   cmd_e   : command codes understood by the light controller
//   op_e    : high-level request operations accepted by the sequencer
//   state_e : sequencer FSM states
//   dur_t   : 16-bit duration in milliseconds
package tl_pkg;

  typedef enum logic [2:0] {
    CMD_START   = 3'd0,
    CMD_OFF     = 3'd1,
    CMD_NOTRANS = 3'd2,
    CMD_SET_G   = 3'd3,
    CMD_SET_R   = 3'd4,
    CMD_SET_Y   = 3'd5
  } cmd_e;

  typedef enum logic [1:0] {
    OP_PROGRAM = 2'd0,
    OP_OFF     = 2'd1,
    OP_ON      = 2'd2,
    OP_MAINT   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_NOTRANS = 3'd1,
    ST_SET_G   = 3'd2,
    ST_SET_R   = 3'd3,
    ST_SET_Y   = 3'd4,
    ST_START   = 3'd5,
    ST_OFF     = 3'd6,
    ST_HOLD    = 3'd7
  } state_e;

  typedef logic [15:0] dur_t;

  // Durations below the floor would underflow the controller's timers.
  function automatic dur_t clamp_dur(input dur_t d, input dur_t min_d);
    return (d < min_d) ? min_d : d;
  endfunction

endpackage

// File: rtl/tl_rr_arbiter.sv
// Two-way request arbiter.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   req_i          : request bits
//   accept_i       : a grant was taken this cycle (moves priority)
//   grant_o        : one-hot grant (zero when no request)
// Build option: TL_SEQ_RR_EN selects round-robin; otherwise fixed
// priority with requester 0 winning ties and no priority state.
module tl_rr_arbiter (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

`ifdef TL_SEQ_RR_EN
  // prio_q = 1 means requester 1 wins a tie.
  logic prio_q;

  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) grant_o = prio_q ? 2'b10 : 2'b01;
  end

  // After a grant the other requester becomes favoured.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)      prio_q <= 1'b0;
    else if (accept_i) prio_q <= grant_o[0];
  end
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, clk_i, rst_n_i, accept_i};

  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) grant_o = 2'b01;
  end
`endif

endmodule

// File: rtl/tl_cfg_sequencer.sv
// Command sequencer and two-port arbiter for the light controller.
// Expands granted requests into per-cycle controller commands; timing
// updates are always bracketed by enter-maintenance and restart.
//   req_valid_i/req_ready_o : per-requester handshake. A transfer occurs
//     when valid & ready in a cycle; ready is combinational, only in IDLE
//     and only for the arbitration winner; requester holds op/data stable.
//   req_op_i, req_green_i, req_red_i, req_yellow_i : request payload
//   cmd_valid_o, cmd_type_o, cmd_data_o : command stream (registered)
//   busy_o      : high from accept through end of holdoff
//   owner_o     : last granted requester
//   clamp_cnt_o : saturating count of clamped durations
//   dbg_state_o : current FSM state
// Build option: TL_SEQ_RR_EN (round-robin arbitration, see tl_rr_arbiter).
module tl_cfg_sequencer
  import tl_pkg::*;
#(
  parameter int MIN_TIME_MS    = 1,
  parameter int HOLDOFF_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [1:0]       req_valid_i,
  output logic [1:0]       req_ready_o,
  input  logic [1:0][1:0]  req_op_i,
  input  logic [1:0][15:0] req_green_i,
  input  logic [1:0][15:0] req_red_i,
  input  logic [1:0][15:0] req_yellow_i,
  output logic             cmd_valid_o,
  output logic [2:0]       cmd_type_o,
  output logic [15:0]      cmd_data_o,
  output logic             busy_o,
  output logic             owner_o,
  output logic [7:0]       clamp_cnt_o,
  output logic [2:0]       dbg_state_o
);

  localparam dur_t       MIN_D     = dur_t'(MIN_TIME_MS);
  localparam logic [15:0] HOLD_INIT = (HOLDOFF_CYCLES > 0) ? 16'(HOLDOFF_CYCLES - 1) : 16'd0;

  state_e      state_q;
  op_e         op_q;
  dur_t        green_q, red_q, yellow_q;
  logic [15:0] hold_q;

  logic [1:0]  grant;
  logic        accept;
  logic        sel;
  op_e         op_in;
  dur_t        g_in, r_in, y_in;
  logic [1:0]  n_clamp;
  logic [8:0]  clamp_sum;

  tl_rr_arbiter u_arb (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .req_i    (req_valid_i),
    .accept_i (accept),
    .grant_o  (grant)
  );

  assign req_ready_o = (state_q == ST_IDLE) ? grant : 2'b00;
  assign accept      = |(req_valid_i & req_ready_o);
  assign sel         = req_ready_o[1];
  assign op_in       = op_e'(req_op_i[sel]);
  assign g_in        = req_green_i[sel];
  assign r_in        = req_red_i[sel];
  assign y_in        = req_yellow_i[sel];
  assign n_clamp     = 2'(g_in < MIN_D) + 2'(r_in < MIN_D) + 2'(y_in < MIN_D);
  assign clamp_sum   = {1'b0, clamp_cnt_o} + {7'd0, n_clamp};
  assign dbg_state_o = state_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_PROGRAM;
      green_q     <= '0;
      red_q       <= '0;
      yellow_q    <= '0;
      hold_q      <= '0;
      cmd_valid_o <= 1'b0;
      cmd_type_o  <= 3'd0;
      cmd_data_o  <= '0;
      busy_o      <= 1'b0;
      owner_o     <= 1'b0;
      clamp_cnt_o <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q        <= op_in;
            green_q     <= clamp_dur(g_in, MIN_D);
            red_q       <= clamp_dur(r_in, MIN_D);
            yellow_q    <= clamp_dur(y_in, MIN_D);
            owner_o     <= sel;
            busy_o      <= 1'b1;
            cmd_valid_o <= 1'b1;
            cmd_data_o  <= '0;
            clamp_cnt_o <= (clamp_sum > 9'd255) ? 8'hFF : clamp_sum[7:0];
            case (op_in)
              OP_PROGRAM, OP_MAINT: begin
                state_q    <= ST_NOTRANS;
                cmd_type_o <= CMD_NOTRANS;
              end
              OP_OFF: begin
                state_q    <= ST_OFF;
                cmd_type_o <= CMD_OFF;
              end
              default: begin
                state_q    <= ST_START;
                cmd_type_o <= CMD_START;
              end
            endcase
          end
        end
        ST_NOTRANS: begin
          if (op_q == OP_PROGRAM) begin
            state_q    <= ST_SET_G;
            cmd_type_o <= CMD_SET_G;
            cmd_data_o <= green_q;
          end else begin
            // MAINT ends after the single no-transition command.
            cmd_valid_o <= 1'b0;
            cmd_type_o  <= 3'd0;
            cmd_data_o  <= '0;
            if (HOLDOFF_CYCLES == 0) begin
              state_q <= ST_IDLE;
              busy_o  <= 1'b0;
            end else begin
              state_q <= ST_HOLD;
              hold_q  <= HOLD_INIT;
            end
          end
        end
        ST_SET_G: begin
          state_q    <= ST_SET_R;
          cmd_type_o <= CMD_SET_R;
          cmd_data_o <= red_q;
        end
        ST_SET_R: begin
          state_q    <= ST_SET_Y;
          cmd_type_o <= CMD_SET_Y;
          cmd_data_o <= yellow_q;
        end
        ST_SET_Y: begin
          state_q    <= ST_START;
          cmd_type_o <= CMD_START;
          cmd_data_o <= '0;
        end
        ST_START, ST_OFF: begin
          cmd_valid_o <= 1'b0;
          cmd_type_o  <= 3'd0;
          cmd_data_o  <= '0;
          if (HOLDOFF_CYCLES == 0) begin
            state_q <= ST_IDLE;
            busy_o  <= 1'b0;
          end else begin
            state_q <= ST_HOLD;
            hold_q  <= HOLD_INIT;
          end
        end
        ST_HOLD: begin
          // hold_q counts down to zero, giving HOLDOFF_CYCLES cycles here.
          if (hold_q == 16'd0) begin
            state_q <= ST_IDLE;
            busy_o  <= 1'b0;
          end else begin
            hold_q <= hold_q - 16'd1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cmd_valid_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/tl_cfg_sequencer.md
# tl_cfg_sequencer

Command sequencer and two-port arbiter in front of the traffic-light controller's command port. It accepts high-level requests (program timings, turn off, turn on, maintenance) from two requesters over valid/ready, arbitrates between them, and expands each granted request into the exact per-cycle `cmd_type`/`cmd_valid`/`cmd_data` sequence the light controller needs. Timing updates are only legal in the controller's no-transition state, so the sequencer always brackets them with enter-maintenance and restart commands.

## Interface
Parameters:
- `MIN_TIME_MS`, 1 — lower clamp for every programmed duration. A zero duration would underflow the controller's timers.
- `HOLDOFF_CYCLES`, 4 — idle cycles forced after each completed request before the next grant.

Ports:
- `clk_i` input 1 — clock.
- `rst_n_i` input 1 — reset, asynchronous, active-low.
- `req_valid_i` input [1:0] — per-requester request valid.
- `req_ready_o` output [1:0] — per-requester accept. At most one bit is high.
- `req_op_i` input [1:0][1:0] — per-requester op: 0 PROGRAM, 1 OFF, 2 ON, 3 MAINT.
- `req_green_i`, `req_red_i`, `req_yellow_i` input [1:0][15:0] — per-requester durations in ms. Used by PROGRAM only.
- `cmd_valid_o` output 1 — command strobe to the light controller.
- `cmd_type_o` output 3 — command code.
- `cmd_data_o` output 16 — command payload.
- `busy_o` output 1 — high from accept through the end of holdoff.
- `owner_o` output 1 — index of the requester last granted.
- `clamp_cnt_o` output 8 — saturating count of durations clamped to `MIN_TIME_MS`.

## Operation
- Handshake: a transfer happens when `req_valid_i[k] & req_ready_o[k]` in a cycle.
  - `req_ready_o` is combinational from arbitration. It is high only in IDLE and only for the winner.
  - The requester holds op and data stable while valid is high. Dropping valid before ready is a protocol violation (undefined).
- On accept, op and the three durations are registered. Any duration below `MIN_TIME_MS` is replaced by `MIN_TIME_MS` and `clamp_cnt_o` increments once per clamped field (so up to +3 per request), saturating at 255.
- FSM states: IDLE, NOTRANS, SET_G, SET_R, SET_Y, START, OFF, HOLD.
  - PROGRAM: NOTRANS, SET_G, SET_R, SET_Y, START, HOLD.
  - OFF: OFF, HOLD.
  - ON: START, HOLD.
  - MAINT: NOTRANS, HOLD.
  - HOLD lasts `HOLDOFF_CYCLES` cycles, then returns to IDLE. If `HOLDOFF_CYCLES`=0, HOLD is skipped.
- Command codes emitted: START=0, OFF=1, NOTRANS=2, SET_G=3, SET_R=4, SET_Y=5.
  - `cmd_data_o` carries the clamped duration for codes 3/4/5 and is 0 otherwise.
- Arbitration: both valid in IDLE resolves per the Configuration section. `owner_o` updates on accept.
- Reset (asserted at any time, including mid-sequence):
  - FSM returns to IDLE and the sequence is abandoned; no partial sequence resumes.
  - All outputs go 0, `clamp_cnt_o` clears, priority favours requester 0.
  - Light-controller state is not repaired here; system reset covers both blocks.

## Timing
- All outputs except `req_ready_o` are registered.
- Accept in cycle N gives the first `cmd_valid_o` at N+1.
  - PROGRAM: `cmd_valid_o` high N+1..N+5 with types 2,3,4,5,0, one command per cycle, no gaps.
  - Single-command ops: `cmd_valid_o` high at N+1 only.
- Next possible accept:
  - PROGRAM: N+6+`HOLDOFF_CYCLES`.
  - Single-command ops: N+2+`HOLDOFF_CYCLES`.
- `busy_o` rises at N+1 and falls in the cycle `req_ready_o` can first go high again.
- Idle outputs: `cmd_valid_o`=0, `cmd_type_o`=0, `cmd_data_o`=0.

## Configuration
- `TL_SEQ_RR_EN` defined: round-robin arbitration. After each grant, priority moves to the other requester, so alternating requests are served fairly.
- Not defined: fixed priority; requester 0 always wins a tie. No priority state is kept.

## Structure
- Shared package `tl_pkg` holds:
  - the command-code enum (shared with the light controller);
  - the request-op enum;
  - the FSM state enum;
  - the 16-bit duration typedef.
- Sub-module `tl_rr_arbiter`: 2-way arbiter with grant, update-on-accept input, and the `TL_SEQ_RR_EN` switch inside it.

## Test plan
- Reset release, req0 PROGRAM g=3000 r=1500 y=800 → `cmd_valid_o` on 5 consecutive cycles with type/data (2,0), (3,3000), (4,1500), (5,800), (0,0); `busy_o` then low after 4 holdoff cycles.
- PROGRAM with g=0, r=0, y=500 → data 1, 1, 500; `clamp_cnt_o`=2.
- Both requesters valid with OFF/ON continuously (RR build) → grants alternate 0,1,0,1; cmd types 1,0,1,0, each spaced 6 cycles apart. Fixed-priority build → only requester 0 is served.
- `HOLDOFF_CYCLES`=0, back-to-back MAINT from req1 → accepts every 2 cycles; `cmd_type_o`=2 each time.
- `rst_n_i` pulsed low during SET_R → `cmd_valid_o` drops asynchronously; after release, FSM is in IDLE, `req_ready_o` follows `req_valid_i`, and no further commands issue.
- Force 300 clamped fields → `clamp_cnt_o` saturates at 255.
